// File: rtl/boa_dma_pkg.sv
// Shared types and constants for the boa DMA copy engine.
package boa_dma_pkg;

    // Copy engine FSM: one read, one capture, one write per word, then a
    // single finish cycle that carries the done pulse.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        RCAP = 3'd2,
        WR   = 3'd3,
        FIN  = 3'd4
    } copier_state_t;

    // Byte-lane mask for a full 32-bit word write.
    localparam logic [3:0] WE_FULL_WORD = 4'hF;

endpackage : boa_dma_pkg

// File: rtl/boa_mem_bus.sv
// Word-addressed CPU-side memory bus shared by initiators and MMIO responders.
// A request is accepted on a rising edge where re or any we bit is high and
// ready is high; read data appears on rdata in the cycle after acceptance.
interface boa_mem_bus #(
    parameter int alen = 32
) ();

    logic [alen-1:2] addr;
    logic            re;
    logic [3:0]      we;
    logic [31:0]     wdata;
    logic            ready;
    logic [31:0]     rdata;

    modport CPU (
        output addr,
        output re,
        output we,
        output wdata,
        input  ready,
        input  rdata
    );

    modport MEM (
        input  addr,
        input  re,
        input  we,
        input  wdata,
        output ready,
        output rdata
    );

endinterface : boa_mem_bus

// File: rtl/boa_mem_copier.sv
// Minimal DMA copy engine: copies len words from src to dst, one read then
// one write per word, strictly ascending. Bus outputs depend on registered
// state only, so there is no combinational path from ready to the bus.
module boa_mem_copier
    import boa_dma_pkg::*;
#(
    parameter int len_w = 16,
    parameter int alen  = 32
) (
    input  logic             clk,
    input  logic             rst,
    boa_mem_bus.CPU          bus,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [len_w-1:0] len,
    output logic             busy,
    output logic             done
);

    // Word-address width; address counters wrap silently at this width.
    localparam int AW = alen - 2;

    localparam logic [AW-1:0]    WORD_STEP = AW'(1);
    localparam logic [len_w-1:0] LEN_ONE   = len_w'(1);
    localparam logic [len_w-1:0] LEN_ZERO  = '0;

    copier_state_t    state_q, state_d;
    logic [AW-1:0]    src_q, src_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic [len_w-1:0] rem_q, rem_d;
    logic [31:0]      data_q, data_d;

    // Byte addresses reduced to word addresses; the byte-offset bits and any
    // bits above the bus address width are deliberately ignored.
    logic [31:0] src_word;
    logic [31:0] dst_word;
    logic        unused_bits;

    assign src_word    = {2'b00, src_addr[31:2]};
    assign dst_word    = {2'b00, dst_addr[31:2]};
    assign unused_bits = ^{src_addr[1:0], dst_addr[1:0],
                           src_word[31:AW], dst_word[31:AW]};

    // Next-state and counter update for the copy sequence.
    always_comb begin
        // NOTE: every _d signal takes its hold value first, so no branch can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != LEN_ZERO) begin
                        src_d   = src_word[AW-1:0];
                        dst_d   = dst_word[AW-1:0];
                        rem_d   = len;
                        state_d = RD;
                    end else begin
                        state_d = FIN;
                    end
                end
            end

            RD: begin
                if (bus.ready) begin
                    state_d = RCAP;
                end
            end

            RCAP: begin
                data_d  = bus.rdata;
                state_d = WR;
            end

            WR: begin
                if (bus.ready) begin
                    src_d = src_q + WORD_STEP;
                    dst_d = dst_q + WORD_STEP;
                    rem_d = rem_q - LEN_ONE;
                    // Decide on the pre-decrement count so a full-scale len
                    // runs all its words before finishing.
                    state_d = (rem_q == LEN_ONE) ? FIN : RD;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            // NOTE: the data register is a single word rather than a memory
            // array, so it is reset along with the counters and wdata never
            // starts out unknown.
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register takes its
            // pre-edge value into account regardless of statement order.
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
        end
    end

    // Bus drive and status, decoded from registered state only.
    always_comb begin
        bus.re    = 1'b0;
        bus.we    = 4'h0;
        bus.addr  = '0;
        bus.wdata = '0;

        case (state_q)
            RD: begin
                bus.re   = 1'b1;
                bus.addr = src_q;
            end
            WR: begin
                bus.we    = WE_FULL_WORD;
                bus.addr  = dst_q;
                bus.wdata = data_q;
            end
            default: begin
                bus.re = 1'b0;
            end
        endcase

        busy = (state_q != IDLE);
        done = (state_q == FIN);
    end

endmodule : boa_mem_copier

// File: tb/tb_boa_mem_copier.sv
// Self-checking bench for boa_mem_copier: a bench-side memory responder with
// optional random or scripted ready stalls, and a behavioural copy model that
// predicts the ordered bus transactions, data and done timing of each copy.
module tb_boa_mem_copier;

    localparam int ALEN   = 16;
    localparam int LEN_W  = 8;
    localparam int AW     = ALEN - 2;
    localparam int NWORDS = 1 << AW;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] a;
        logic [31:0]   d;
    } txn_t;

    localparam logic [31:0] BASIC [4] = '{32'h0000_00A0, 32'h0000_00A1,
                                          32'h0000_00A2, 32'h0000_00A3};

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;

    boa_mem_bus #(.alen(ALEN)) bus_if ();

    boa_mem_copier #(.len_w(LEN_W), .alen(ALEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Responder memory and the model's view of what memory must contain.
    logic [31:0] mem       [NWORDS];
    logic [31:0] model_mem [NWORDS];

    int            cyc   = 0;
    bit            armed = 1'b0;
    bit            acc_rd = 1'b0;
    bit            acc_wr = 1'b0;
    logic [AW-1:0] acc_addr  = '0;
    logic [31:0]   acc_wdata = '0;

    // Responder: applies transactions the monitor saw accepted at this edge.
    always @(posedge clk) begin
        if (acc_rd) bus_if.rdata <= mem[acc_addr];
        else        bus_if.rdata <= $urandom;
        if (acc_wr) mem[acc_addr] = acc_wdata;
        cyc   = cyc + 1;
        armed = 1'b1;
    end

    // Model / monitor state.
    bit            rand_ready    = 1'b0;
    int            rd_stall_left = 0;
    int            wr_stall_left = 0;
    bit            copy_active   = 1'b0;
    int            start_cyc     = 0;
    int            cur_len       = 0;
    logic [AW-1:0] cur_dst       = '0;
    int            stall_cnt     = 0;
    int            last_cycles   = -1;
    int            done_pulses   = 0;
    int            wr_cnt        = 0;
    txn_t          exp_q [$];
    logic [AW-1:0] rd_log [$];

    bit            prev_stalled = 1'b0;
    logic          prev_re;
    logic [3:0]    prev_we;
    logic [AW-1:0] prev_addr;
    logic [31:0]   prev_wdata;

    // Per-cycle compare process, half a cycle away from the active edge.
    always @(negedge clk) begin : monitor
        bit            active0, req, rdy, exp_busy, exp_done;
        txn_t          t;
        logic [AW-1:0] s, d, idx;
        logic [31:0]   wv;
        if (!armed) begin
            bus_if.ready = 1'b0;
        end else begin
            active0 = copy_active;
            req     = bus_if.re || (bus_if.we != 4'h0);

            if (rst) rdy = 1'b0;
            else if (bus_if.re && rd_stall_left > 0) begin
                rdy = 1'b0; rd_stall_left--;
            end else if (bus_if.we != 4'h0 && wr_stall_left > 0) begin
                rdy = 1'b0; wr_stall_left--;
            end else rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus_if.ready = rdy;

            if (prev_stalled) begin
                check("hold_re",    bus_if.re,    prev_re);
                check("hold_we",    bus_if.we,    prev_we);
                check("hold_addr",  bus_if.addr,  prev_addr);
                check("hold_wdata", bus_if.wdata, prev_wdata);
            end

            exp_busy = copy_active && (cyc > start_cyc);
            exp_done = copy_active && (cyc - start_cyc == 3 * cur_len + 1 + stall_cnt);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            if (done) done_pulses++;

            if (req) begin
                check("req_pending", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    t = exp_q[0];
                    check("req_re",   bus_if.re,   !t.wr);
                    check("req_we",   bus_if.we,   t.wr ? 4'hF : 4'h0);
                    check("req_addr", bus_if.addr, t.a);
                    if (t.wr) check("req_wdata", bus_if.wdata, t.d);
                    if (rdy) void'(exp_q.pop_front());
                end
                acc_rd    = rdy && bus_if.re;
                acc_wr    = rdy && (bus_if.we != 4'h0);
                acc_addr  = bus_if.addr;
                acc_wdata = bus_if.wdata;
                if (acc_rd) rd_log.push_back(bus_if.addr);
                if (acc_wr) wr_cnt++;
                if (!rdy) stall_cnt++;
                prev_stalled = !rdy;
                prev_re      = bus_if.re;
                prev_we      = bus_if.we;
                prev_addr    = bus_if.addr;
                prev_wdata   = bus_if.wdata;
            end else begin
                acc_rd = 1'b0;
                acc_wr = 1'b0;
                check("idle_addr",  bus_if.addr,  '0);
                check("idle_wdata", bus_if.wdata, '0);
                prev_stalled = 1'b0;
            end

            if (exp_done) begin
                check("queue_drained", exp_q.size(), 0);
                last_cycles = cyc - start_cyc;
                for (int i = 0; i < cur_len; i++) begin
                    idx = cur_dst + AW'(i);
                    check("dst_word", mem[idx], model_mem[idx]);
                end
                copy_active = 1'b0;
            end

            // A copy in the model: ascending word-by-word, so overlapping
            // regions see earlier writes when later words are read.
            if (start && !rst && !active0) begin
                s = src_addr[ALEN-1:2];
                d = dst_addr[ALEN-1:2];
                start_cyc   = cyc;
                cur_len     = int'(len);
                cur_dst     = d;
                stall_cnt   = 0;
                copy_active = 1'b1;
                for (int i = 0; i < int'(len); i++) begin
                    wv = model_mem[s + AW'(i)];
                    model_mem[d + AW'(i)] = wv;
                    exp_q.push_back('{wr: 1'b0, a: s + AW'(i), d: 32'h0});
                    exp_q.push_back('{wr: 1'b1, a: d + AW'(i), d: wv});
                end
            end

            if (rst) begin
                copy_active  = 1'b0;
                exp_q.delete();
                prev_stalled = 1'b0;
            end
        end
    end

    task automatic clear_logs();
        rd_log.delete();
        wr_cnt      = 0;
        done_pulses = 0;
        last_cycles = -1;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input int l);
        @(posedge clk); #1;
        src_addr = s;
        dst_addr = d;
        len      = LEN_W'(l);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic resync_model();
        for (int i = 0; i < NWORDS; i++) model_mem[i] = mem[i];
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        resync_model();
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && copy_active; k++) @(posedge clk);
        #1;
        check("copy_finished", copy_active, 1'b0);
        if (copy_active) do_reset();
    endtask

    initial begin
        #1_000_000;
        $display("Watchdog expired before the summary line");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_seen;
        rst      = 1'b1;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        for (int i = 0; i < NWORDS; i++) begin
            mem[i]       = $urandom;
            model_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[14'h40 + i]       = BASIC[i];
            model_mem[14'h40 + i] = BASIC[i];
        end
        mem[14'h0C0]       = 32'h5EED_0001;
        model_mem[14'h0C0] = 32'h5EED_0001;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_re",   bus_if.re, 1'b0);
        check("rst_we",   bus_if.we, 4'h0);
        check("rst_addr", bus_if.addr, '0);
        rst = 1'b0;

        // Basic four-word copy with ready tied high.
        clear_logs();
        launch(32'h100, 32'h200, 4);
        wait_idle(100);
        check("basic_cycles", last_cycles, 13);
        check("basic_writes", wr_cnt, 4);
        check("basic_reads", rd_log.size(), 4);
        if (rd_log.size() == 4)
            for (int i = 0; i < 4; i++) check("basic_rd_addr", rd_log[i], 14'h40 + i);
        for (int i = 0; i < 4; i++) check("basic_dst", mem[14'h80 + i], BASIC[i]);

        // Scripted stalls: three on the first read, two on the first write.
        clear_logs();
        rd_stall_left = 3;
        wr_stall_left = 2;
        launch(32'h300, 32'h400, 1);
        wait_idle(50);
        check("stall_cycles", last_cycles, 9);
        check("stall_data", mem[14'h100], 32'h5EED_0001);

        // Zero length: finish with no bus traffic.
        clear_logs();
        launch(32'h500, 32'h600, 0);
        wait_idle(10);
        check("zero_cycles", last_cycles, 1);
        check("zero_reads", rd_log.size(), 0);
        check("zero_writes", wr_cnt, 0);
        check("zero_done_pulses", done_pulses, 1);

        // Start while busy is ignored, as are input changes.
        clear_logs();
        launch(32'h700, 32'h780, 2);
        repeat (2) @(posedge clk);
        #1;
        src_addr = 32'h900;
        dst_addr = 32'hA00;
        len      = LEN_W'(5);
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        wait_idle(50);
        check("busy_reads", rd_log.size(), 2);
        if (rd_log.size() == 2) begin
            check("busy_rd0", rd_log[0], 14'h1C0);
            check("busy_rd1", rd_log[1], 14'h1C1);
        end
        check("busy_done_pulses", done_pulses, 1);
        check("busy_cycles", last_cycles, 7);

        // Source address wraps at the top of the word-address space.
        clear_logs();
        launch(32'hFFFC, 32'h1000, 2);
        wait_idle(50);
        check("wrap_reads", rd_log.size(), 2);
        if (rd_log.size() == 2) begin
            check("wrap_rd0", rd_log[0], 14'h3FFF);
            check("wrap_rd1", rd_log[1], 14'h0000);
        end

        // Reset during the third write aborts the copy.
        clear_logs();
        launch(32'h2000, 32'h3000, 8);
        wr_seen = 0;
        for (int k = 0; k < 100 && wr_seen < 3; k++) begin
            @(posedge clk); #1;
            if (bus_if.we != 4'h0) wr_seen++;
        end
        check("abort_reached_wr3", wr_seen, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_re",   bus_if.re, 1'b0);
        check("abort_we",   bus_if.we, 4'h0);
        check("abort_busy", busy, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_pulses, 0);
        check("abort_writes", wr_cnt, 2);
        resync_model();
        clear_logs();
        launch(32'h2000, 32'h3000, 3);
        wait_idle(50);
        check("post_abort_cycles", last_cycles, 10);
        check("post_abort_writes", wr_cnt, 3);

        // Full-scale count over an overlapping region with random stalls.
        rand_ready = 1'b1;
        clear_logs();
        launch(32'h8000, 32'h8100, (1 << LEN_W) - 1);
        wait_idle(8 * 255 + 100);
        check("full_writes", wr_cnt, 255);
        check("full_reads", rd_log.size(), 255);
        check("full_done_pulses", done_pulses, 1);

        // Randomised copies, sometimes with a stray start during the copy.
        for (int n = 0; n < 12; n++) begin
            launch($urandom, $urandom, $urandom_range(1, 16));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 60)) @(posedge clk);
                launch($urandom, $urandom, $urandom_range(0, 16));
            end
            wait_idle(600);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_boa_mem_copier
